// File: rtl/depth_pkg.sv
// Shared constants and FSM encoding for the disparity-to-depth conversion stage.
package depth_pkg;

    localparam int              NUM_W        = 16;
    localparam logic [15:0]     K            = 16'd12000;
    localparam int              DEPTH_W      = 8;
    localparam int              FRAME_PIXELS = 1280;
    localparam int              ADDR_W       = 11;
    localparam int              DISP_W       = 6;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DIV   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

endpackage

// File: rtl/seq_divider.sv
// Bit-serial restoring divider: one quotient bit per cycle, NUM_W cycles per divide.
module seq_divider
    import depth_pkg::*;
#(
    parameter int NUM_W = 16,
    parameter int DIV_W = DISP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quotient
);

    localparam int REM_W = DIV_W + 1;
    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [REM_W-1:0] rem_q, rem_d;
    logic [NUM_W-1:0] quo_q, quo_d;
    logic [DIV_W-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REM_W-1:0] rem_shift;

    // The remainder stays below the divisor, so one guard bit holds the shifted value.
    assign rem_shift = {rem_q[REM_W-2:0], quo_q[NUM_W-1]};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (start && !busy) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = CNT_W'(NUM_W);
        end else if (busy) begin
            if (rem_shift >= {1'b0, dvs_q}) begin
                rem_d = rem_shift - {1'b0, dvs_q};
                quo_d = {quo_q[NUM_W-2:0], 1'b1};
            end else begin
                rem_d = rem_shift;
                quo_d = {quo_q[NUM_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    // done marks the final step; quotient holds the result from the following cycle.
    assign busy     = (cnt_q != '0);
    assign done     = (cnt_q == CNT_W'(1));
    assign quotient = quo_q;

endmodule

// File: rtl/depth_calc.sv
// Converts each accepted disparity to depth = K / d and writes it to the depth-map RAM.
module depth_calc
    import depth_pkg::*;
#(
    parameter int              NUM_W        = depth_pkg::NUM_W,
    parameter logic [NUM_W-1:0] K           = depth_pkg::K,
    parameter int              DEPTH_W      = depth_pkg::DEPTH_W,
    parameter int              FRAME_PIXELS = depth_pkg::FRAME_PIXELS,
    parameter int              ADDR_W       = depth_pkg::ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               d_valid,
    input  logic [DISP_W-1:0]  d,
    output logic               d_ready,
    input  logic               frame_start,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [DEPTH_W-1:0] wr_data,
    output logic               frame_done
);

    logic [1:0]        state_q, state_d;
    logic              inf_q, inf_d;
    logic [ADDR_W-1:0] pix_q, pix_d;
    logic              div_start, div_busy, div_done;
    logic [NUM_W-1:0]  div_quotient;

    seq_divider #(
        .NUM_W (NUM_W),
        .DIV_W (DISP_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (K),
        .divisor  (d),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_comb begin
        state_d   = state_q;
        inf_d     = inf_q;
        div_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (d_valid) begin
                    if (d != '0) begin
                        div_start = 1'b1;
                        inf_d     = 1'b0;
                        state_d   = S_DIV;
                    end else begin
                        // Zero disparity means infinite depth: skip the divider.
                        inf_d   = 1'b1;
                        state_d = S_WRITE;
                    end
                end
            end
            S_DIV:   if (div_done) state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // frame_start has priority over the post-write increment.
    always_comb begin
        pix_d = pix_q;
        if (frame_start) begin
            pix_d = '0;
        end else if (wr_en) begin
            pix_d = (pix_q == ADDR_W'(FRAME_PIXELS - 1)) ? '0 : pix_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            inf_q   <= 1'b0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            inf_q   <= inf_d;
            pix_q   <= pix_d;
        end
    end

    assign d_ready    = (state_q == S_IDLE);
    assign wr_en      = (state_q == S_WRITE);
    assign wr_addr    = pix_q;
    assign wr_data    = (inf_q || (|div_quotient[NUM_W-1:DEPTH_W])) ? '1
                                                                      : div_quotient[DEPTH_W-1:0];
    assign frame_done = wr_en && (pix_q == ADDR_W'(FRAME_PIXELS - 1));

endmodule

// File: tb/tb_depth_calc.sv
// Randomized self-checking bench for depth_calc against a plain-arithmetic depth model.
module tb_depth_calc;

    localparam int K_VAL  = 12000;
    localparam int PIXELS = 1280;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d_valid;
    logic [5:0]  d;
    logic        d_ready;
    logic        frame_start;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        frame_done;

    int total = 0;
    int bad   = 0;
    int mdl_cnt = 0;
    int frames_seen = 0;

    depth_calc dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .d_valid     (d_valid),
        .d           (d),
        .d_ready     (d_ready),
        .frame_start (frame_start),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    function automatic int ref_depth(input int dv);
        int q;
        if (dv == 0) return 255;
        q = K_VAL / dv;
        return (q > 255) ? 255 : q;
    endfunction

    // One full transaction; fs_mode 1 pulses frame_start during WRITE, 2 pulses it mid-divide.
    task automatic do_pixel(input int dv, input int fs_mode);
        int  exp_lat, exp_data, c, k;
        bit  seen, ready_bad;
        exp_data  = ref_depth(dv);
        exp_lat   = (dv == 0) ? 1 : 17;
        @(negedge clk);
        d_valid = 1'b1;
        d       = 6'(dv);
        k = 0;
        while (!d_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (!d_ready) begin
            bad++;
            $display("FAIL accept_timeout: d_ready=%0b required 1 within 50 cycles", d_ready);
            d_valid = 1'b0;
            return;
        end
        @(negedge clk);
        d_valid = 1'b0;
        d       = 6'($urandom);
        seen = 1'b0;
        ready_bad = 1'b0;
        c = 1;
        while (!seen && c <= 40) begin
            frame_start = (fs_mode == 2 && c == 5);
            if (frame_start) mdl_cnt = 0;
            if (d_ready) ready_bad = 1'b1;
            if (wr_en) begin
                seen = 1'b1;
                total += 4;
                if (c !== exp_lat) begin
                    bad++;
                    $display("FAIL latency d=%0d: got %0d cycles required %0d", dv, c, exp_lat);
                end
                if (wr_addr !== 11'(mdl_cnt)) begin
                    bad++;
                    $display("FAIL wr_addr d=%0d: got %0d required %0d", dv, wr_addr, mdl_cnt);
                end
                if (wr_data !== 8'(exp_data)) begin
                    bad++;
                    $display("FAIL wr_data d=%0d: got %0d required %0d", dv, wr_data, exp_data);
                end
                if (frame_done !== (mdl_cnt == PIXELS - 1)) begin
                    bad++;
                    $display("FAIL frame_done addr=%0d: got %0b required %0b",
                             mdl_cnt, frame_done, (mdl_cnt == PIXELS - 1));
                end
                if (frame_done) frames_seen++;
                if (fs_mode == 1) begin
                    frame_start = 1'b1;
                    mdl_cnt = 0;
                end else begin
                    mdl_cnt = (mdl_cnt + 1) % PIXELS;
                end
            end
            @(negedge clk);
            c++;
        end
        frame_start = 1'b0;
        total += 2;
        if (!seen) begin
            bad++;
            $display("FAIL write_timeout d=%0d: no wr_en within 40 cycles", dv);
        end
        if (ready_bad) begin
            bad++;
            $display("FAIL busy_ready d=%0d: d_ready=1 while busy, required 0", dv);
        end
        total++;
        if (d_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_return d=%0d: got %0b required 1", dv, d_ready);
        end
    endtask

    task automatic pulse_frame_start();
        @(negedge clk);
        frame_start = 1'b1;
        mdl_cnt = 0;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        d_valid = 1'b0;
        d = '0;
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total += 5;
        if (d_ready !== 1'b1)     begin bad++; $display("FAIL reset_d_ready: got %0b required 1", d_ready); end
        if (wr_en !== 1'b0)       begin bad++; $display("FAIL reset_wr_en: got %0b required 0", wr_en); end
        if (wr_addr !== 11'd0)    begin bad++; $display("FAIL reset_wr_addr: got %0d required 0", wr_addr); end
        if (wr_data !== 8'd0)     begin bad++; $display("FAIL reset_wr_data: got %0d required 0", wr_data); end
        if (frame_done !== 1'b0)  begin bad++; $display("FAIL reset_frame_done: got %0b required 0", frame_done); end
        mdl_cnt = 0;
    endtask

    task automatic test_basic();
        do_pixel(60, 0);
        do_pixel(0, 0);
        do_pixel(48, 0);
        do_pixel(47, 0);
        do_pixel(1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) do_pixel(int'($urandom_range(0, 63)), 0);
    endtask

    task automatic test_back_to_back();
        int seq [3] = '{63, 60, 30};
        int idx, writes, last_wr;
        bit accept_now;
        pulse_frame_start();
        idx = 0;
        writes = 0;
        last_wr = -1;
        @(negedge clk);
        d_valid = 1'b1;
        d = 6'(seq[0]);
        for (int cyc = 0; cyc < 120; cyc++) begin
            if (wr_en) begin
                total += 2;
                if (writes < 3 && wr_data !== 8'(ref_depth(seq[writes]))) begin
                    bad++;
                    $display("FAIL b2b_data #%0d: got %0d required %0d", writes, wr_data, ref_depth(seq[writes]));
                end
                if (wr_addr !== 11'(mdl_cnt)) begin
                    bad++;
                    $display("FAIL b2b_addr #%0d: got %0d required %0d", writes, wr_addr, mdl_cnt);
                end
                if (last_wr >= 0) begin
                    total++;
                    if (cyc - last_wr != 18) begin
                        bad++;
                        $display("FAIL b2b_spacing #%0d: got %0d required 18", writes, cyc - last_wr);
                    end
                end
                last_wr = cyc;
                writes++;
                mdl_cnt = (mdl_cnt + 1) % PIXELS;
            end
            accept_now = d_valid && d_ready;
            @(negedge clk);
            if (accept_now) begin
                idx++;
                if (idx < 3) d = 6'(seq[idx]);
                else d_valid = 1'b0;
            end
        end
        d_valid = 1'b0;
        total++;
        if (writes != 3) begin
            bad++;
            $display("FAIL b2b_count: got %0d writes required 3", writes);
        end
    endtask

    task automatic test_frame();
        pulse_frame_start();
        frames_seen = 0;
        for (int i = 0; i < PIXELS; i++)
            do_pixel((i % 200 == 17) ? int'($urandom_range(1, 63)) : 0, 0);
        total++;
        if (frames_seen != 1) begin
            bad++;
            $display("FAIL frame_done_count: got %0d required 1", frames_seen);
        end
        do_pixel(int'($urandom_range(0, 63)), 0);
    endtask

    task automatic test_reset_mid();
        bit stray;
        do_pixel(0, 0);
        @(negedge clk);
        d_valid = 1'b1;
        d = 6'd60;
        @(negedge clk);
        d_valid = 1'b0;
        stray = 1'b0;
        for (int c = 1; c < 5; c++) begin
            if (wr_en) stray = 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (d_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_ready: got %0b required 1", d_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mdl_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            if (wr_en) stray = 1'b1;
            @(negedge clk);
        end
        total++;
        if (stray) begin
            bad++;
            $display("FAIL mid_reset_write: wr_en seen=1 required 0");
        end
        do_pixel(60, 0);
    endtask

    task automatic test_frame_start_write();
        pulse_frame_start();
        for (int i = 0; i < 7; i++) do_pixel(0, 0);
        do_pixel(int'($urandom_range(1, 63)), 1);
        do_pixel(0, 0);
        do_pixel(5, 0);
        do_pixel(30, 2);
        do_pixel(0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_frame();
        test_reset_mid();
        test_frame_start_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
